// File: rtl/td4_core_param.sv
// Parametrised TD4-style two-register CPU core: single-cycle execute with fetch stall,
// optional input synchroniser, output-write strobe and retire pulse.
module td4_core_param #(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 4,
  parameter int SYNC_IN = 1
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [DATA_W+3:0] instr,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] in_port,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] out_port,
  output logic              out_strobe,
  output logic              carry,
  output logic              retired
);

  generate
    if (ADDR_W < 1 || ADDR_W > DATA_W) begin : g_bad_addr_w
      $error("td4_core_param: ADDR_W must lie in 1..DATA_W");
    end
  endgenerate

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  function automatic logic [DATA_W:0] alu_add(input logic [DATA_W-1:0] x,
                                              input logic [DATA_W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  logic [3:0]        op;
  logic [DATA_W-1:0] im;
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic [DATA_W-1:0] in_val;
  logic [DATA_W-1:0] operand;
  logic [DATA_W:0]   sum;
  logic              sel_a;
  logic              sel_b;
  logic              ld_a;
  logic              ld_b;
  logic              ld_o;
  logic              ld_p;

  assign op = instr[DATA_W+3:DATA_W];
  assign im = instr[DATA_W-1:0];

  // in_port synchroniser stage boundary (two flops, always clocked regardless of stalls)
  generate
    if (SYNC_IN != 0) begin : g_sync
      logic [DATA_W-1:0] in_p0;
      logic [DATA_W-1:0] in_p1;
      always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
          in_p0 <= '0;
          in_p1 <= '0;
        end else begin
          in_p0 <= in_port;
          in_p1 <= in_p0;
        end
      end
      assign in_val = in_p1;
    end else begin : g_raw
      assign in_val = in_port;
    end
  endgenerate

  assign sel_a = op[0] | op[3];
  assign sel_b = op[1];

  always_comb begin
    operand = '0;
    case ({sel_b, sel_a})
      2'b00:   operand = reg_a;
      2'b01:   operand = reg_b;
      2'b10:   operand = in_val;
      default: operand = '0;
    endcase
  end

  assign sum  = alu_add(operand, im);
  assign ld_a = ~(op[2] | op[3]);
  assign ld_b = op[2] & ~op[3];
  assign ld_o = ~op[2] & op[3];
  // JNC looks at the carry held before this edge, not the one being produced
  assign ld_p = op[2] & op[3] & (op[0] | ~carry);

  // execute stage boundary: all architectural state updates on one edge
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pc         <= '0;
      reg_a      <= '0;
      reg_b      <= '0;
      out_port   <= '0;
      carry      <= 1'b0;
      out_strobe <= 1'b0;
      retired    <= 1'b0;
    end else begin
      out_strobe <= instr_valid & ld_o;
      retired    <= instr_valid;
      if (instr_valid) begin
        carry <= sum[DATA_W];
        if (ld_a) reg_a <= sum[DATA_W-1:0];
        if (ld_b) reg_b <= sum[DATA_W-1:0];
        if (ld_o) out_port <= sum[DATA_W-1:0];
        pc <= ld_p ? im[ADDR_W-1:0] : pc + PC_ONE;
      end
    end
  end

endmodule

// File: tb/tb_td4_core_param.sv
// Bench for td4_core_param: directed program fragments and random instruction streams
// compared against an instruction-level model; side instances cover SYNC_IN=0 and 8/6 widths.
module tb_td4_core_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_reset;
  logic [7:0]  instr;
  logic        instr_valid;
  logic [3:0]  in_port;
  logic [3:0]  pc;
  logic [3:0]  out_port;
  logic        out_strobe;
  logic        carry;
  logic        retired;

  logic        n_reset_b;
  logic [7:0]  instr0;
  logic        valid0;
  logic [3:0]  in0;
  logic [3:0]  pc0;
  logic [3:0]  out0;
  logic        strb0;
  logic        carry0;
  logic        ret0;

  logic [11:0] instr8;
  logic        valid8;
  logic [7:0]  in8;
  logic [5:0]  pc8;
  logic [7:0]  out8;
  logic        strb8;
  logic        carry8;
  logic        ret8;

  logic        aux_done;

  td4_core_param #(.DATA_W(4), .ADDR_W(4), .SYNC_IN(1)) dut (
    .clk(clk), .n_reset(n_reset), .instr(instr), .instr_valid(instr_valid),
    .in_port(in_port), .pc(pc), .out_port(out_port), .out_strobe(out_strobe),
    .carry(carry), .retired(retired)
  );

  td4_core_param #(.DATA_W(4), .ADDR_W(4), .SYNC_IN(0)) dut0 (
    .clk(clk), .n_reset(n_reset_b), .instr(instr0), .instr_valid(valid0),
    .in_port(in0), .pc(pc0), .out_port(out0), .out_strobe(strb0),
    .carry(carry0), .retired(ret0)
  );

  td4_core_param #(.DATA_W(8), .ADDR_W(6), .SYNC_IN(1)) dut8 (
    .clk(clk), .n_reset(n_reset_b), .instr(instr8), .instr_valid(valid8),
    .in_port(in8), .pc(pc8), .out_port(out8), .out_strobe(strb8),
    .carry(carry8), .retired(ret8)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Instruction-level model of the main 4-bit instance
  int m_pc, m_a, m_b, m_out, m_c, m_str, m_ret;
  int syncq[$];

  task automatic model_reset();
    m_pc = 0; m_a = 0; m_b = 0; m_out = 0; m_c = 0; m_str = 0; m_ret = 0;
    syncq = '{0, 0};
  endtask

  task automatic model_edge();
    logic [3:0] op;
    int im, opnd, sum, res, cy, in_now;
    bit jump;
    in_now = syncq[0];
    if (instr_valid) begin
      op = instr[7:4];
      im = int'(instr[3:0]);
      if (op[1]) opnd = (op[0] || op[3]) ? 0 : in_now;
      else       opnd = (op[0] || op[3]) ? m_b : m_a;
      sum = opnd + im;
      res = sum % 16;
      cy  = (sum >= 16) ? 1 : 0;
      if (!op[2] && !op[3]) m_a = res;
      if (op[2] && !op[3])  m_b = res;
      if (!op[2] && op[3])  m_out = res;
      jump  = op[2] && op[3] && (op[0] || (m_c == 0));
      m_pc  = jump ? im : (m_pc + 1) % 16;
      m_c   = cy;
      m_str = (!op[2] && op[3]) ? 1 : 0;
      m_ret = 1;
    end else begin
      m_str = 0;
      m_ret = 0;
    end
    syncq.push_back(int'(in_port));
    syncq.delete(0);
  endtask

  task automatic step(input logic [7:0] ins, input logic v, input logic [3:0] inp);
    @(negedge clk);
    instr = ins; instr_valid = v; in_port = inp;
    @(posedge clk);
    model_edge();
    #1;
    check($sformatf("pc@%02h", ins),         32'(pc),         m_pc);
    check($sformatf("out_port@%02h", ins),   32'(out_port),   m_out);
    check($sformatf("carry@%02h", ins),      32'(carry),      m_c);
    check($sformatf("out_strobe@%02h", ins), 32'(out_strobe), m_str);
    check($sformatf("retired@%02h", ins),    32'(retired),    m_ret);
  endtask

  task automatic step0(input logic [7:0] ins, input logic [3:0] inp);
    @(negedge clk);
    instr0 = ins; valid0 = 1'b1; in0 = inp;
    @(posedge clk);
    #1;
  endtask

  task automatic step8(input logic [11:0] ins);
    @(negedge clk);
    instr8 = ins; valid8 = 1'b1; in8 = 8'h00;
    @(posedge clk);
    #1;
  endtask

  initial begin : main_seq
    logic [3:0] held_pc;
    n_reset = 1'b1; instr = 8'h00; instr_valid = 1'b0; in_port = 4'h0;
    model_reset();
    #1 n_reset = 1'b0;
    #1;
    check("rst_pc",      32'(pc),         0);
    check("rst_out",     32'(out_port),   0);
    check("rst_carry",   32'(carry),      0);
    check("rst_strobe",  32'(out_strobe), 0);
    check("rst_retired", 32'(retired),    0);
    @(posedge clk);
    #1 n_reset = 1'b1;

    // MOV A,3 / ADD A,14 / JNC 5 twice
    step(8'h33, 1'b1, 4'h0);
    step(8'h0E, 1'b1, 4'h0);
    check("add_carry", 32'(carry), 1);
    step(8'hE5, 1'b1, 4'h0);
    check("jnc_not_taken_pc", 32'(pc), 3);
    check("jnc_clears_carry", 32'(carry), 0);
    step(8'hE5, 1'b1, 4'h0);
    check("jnc_taken_pc", 32'(pc), 5);
    step(8'h40, 1'b1, 4'h0);
    step(8'h90, 1'b1, 4'h0);
    check("add_wrap_a", 32'(out_port), 1);

    // OUT im twice: strobe pulses each time, then drops
    step(8'hBA, 1'b1, 4'h0);
    check("out_im", 32'(out_port), 4'hA);
    check("strobe_1", 32'(out_strobe), 1);
    step(8'hBA, 1'b1, 4'h0);
    check("strobe_2", 32'(out_strobe), 1);
    step(8'h33, 1'b1, 4'h0);
    check("strobe_drop", 32'(out_strobe), 0);

    // three stall cycles
    held_pc = pc;
    for (int i = 0; i < 3; i++) begin
      step(8'h5F, 1'b0, 4'h0);
      check("stall_pc", 32'(pc), 32'(held_pc));
      check("stall_retired", 32'(retired), 0);
    end

    // IN A one cycle after in_port changes sees the old value; two cycles later the new one
    step(8'h33, 1'b1, 4'h5);
    step(8'h20, 1'b1, 4'h5);
    step(8'h40, 1'b1, 4'h5);
    step(8'h90, 1'b1, 4'h5);
    check("in_early", 32'(out_port), 0);
    step(8'h33, 1'b1, 4'h9);
    step(8'h33, 1'b1, 4'h9);
    step(8'h20, 1'b1, 4'h9);
    step(8'h40, 1'b1, 4'h9);
    step(8'h90, 1'b1, 4'h9);
    check("in_synced", 32'(out_port), 9);

    // pc wrap
    step(8'hFF, 1'b1, 4'h0);
    check("jmp_15", 32'(pc), 15);
    step(8'h01, 1'b1, 4'h0);
    check("pc_wrap", 32'(pc), 0);

    // build A=7, pc=9, out=3, carry=1, then reset asynchronously mid-cycle
    step(8'h71, 1'b1, 4'h0);
    step(8'hB3, 1'b1, 4'h0);
    step(8'h37, 1'b1, 4'h0);
    step(8'hF8, 1'b1, 4'h0);
    step(8'h5F, 1'b1, 4'h0);
    check("pre_rst_pc", 32'(pc), 9);
    check("pre_rst_carry", 32'(carry), 1);
    #2 n_reset = 1'b0;
    #1;
    check("async_rst_pc",      32'(pc),         0);
    check("async_rst_out",     32'(out_port),   0);
    check("async_rst_carry",   32'(carry),      0);
    check("async_rst_retired", 32'(retired),    0);
    check("async_rst_strobe",  32'(out_strobe), 0);
    model_reset();
    @(posedge clk);
    #1 n_reset = 1'b1;
    step(8'h40, 1'b1, 4'h0);
    step(8'h90, 1'b1, 4'h0);
    check("rst_clears_a", 32'(out_port), 0);

    // random instruction stream
    for (int i = 0; i < 400; i++) begin
      step(8'($urandom_range(0, 255)), ($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)));
    end

    for (int i = 0; i < 2000 && !aux_done; i++) @(posedge clk);
    check("aux_done", 32'(aux_done), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : aux_seq
    aux_done = 1'b0;
    n_reset_b = 1'b1;
    instr0 = 8'h00; valid0 = 1'b0; in0 = 4'h0;
    instr8 = 12'h000; valid8 = 1'b0; in8 = 8'h00;
    #1 n_reset_b = 1'b0;
    #1;
    check("w8_rst_pc", 32'(pc8), 0);
    check("raw_rst_out", 32'(out0), 0);
    @(posedge clk);
    #1 n_reset_b = 1'b1;

    // raw input path: IN is sampled at its own edge
    step0(8'h60, 4'h5);
    check("raw_pc", 32'(pc0), 1);
    step0(8'h90, 4'h9);
    check("raw_in_b", 32'(out0), 5);
    check("raw_strobe", 32'(strb0), 1);
    step0(8'h20, 4'hC);
    step0(8'h40, 4'h0);
    step0(8'h90, 4'h0);
    check("raw_in_a", 32'(out0), 4'hC);
    @(negedge clk);
    valid0 = 1'b0;

    // 8-bit data, 6-bit pc
    step8(12'h3F0);
    step8(12'h020);
    check("w8_add_carry", 32'(carry8), 1);
    check("w8_pc", 32'(pc8), 2);
    step8(12'h400);
    step8(12'h900);
    check("w8_add_wrap", 32'(out8), 8'h10);
    check("w8_carry_clr", 32'(carry8), 0);
    step8(12'hFFF);
    check("w8_jmp_trunc", 32'(pc8), 6'h3F);
    step8(12'h400);
    check("w8_pc_wrap", 32'(pc8), 0);
    @(negedge clk);
    valid8 = 1'b0;
    aux_done = 1'b1;
  end

endmodule
